// File: rtl/xadac_mac_cop.sv
// xadac_mac_cop: coprocessor with one-entry decode response slot and a two-stage
// multiply-accumulate execute pipeline (E1 multiplies, OUT holds result).
module xadac_mac_cop #(
    parameter int IdWidth      = 3,
    parameter int RegDataWidth = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                dec_req_valid,
    output logic                                dec_req_ready,
    input  logic [IdWidth-1:0]                  dec_req_id,
    input  logic [31:0]                         dec_req_instr,
    output logic                                dec_rsp_valid,
    input  logic                                dec_rsp_ready,
    output logic [IdWidth-1:0]                  dec_rsp_id,
    output logic                                dec_rsp_accept,
    input  logic                                exe_req_valid,
    output logic                                exe_req_ready,
    input  logic [IdWidth-1:0]                  exe_req_id,
    input  logic [31:0]                         exe_req_instr,
    input  logic [1:0][RegDataWidth-1:0]        exe_req_rs_data,
    input  logic [1:0][4:0]                     exe_req_rs_addr,
    output logic                                exe_rsp_valid,
    input  logic                                exe_rsp_ready,
    output logic [IdWidth-1:0]                  exe_rsp_id,
    output logic [RegDataWidth-1:0]             exe_rsp_rd_data,
    output logic                                exe_rsp_rd_write
);
    localparam int AW = 2 * RegDataWidth;
    typedef enum logic [1:0] {OP_MAC, OP_CLR, OP_RDL, OP_RDH} op_e;

    logic                    dec_rsp_valid_q, dec_rsp_valid_d;
    logic [IdWidth-1:0]      dec_rsp_id_q, dec_rsp_id_d;
    logic                    dec_rsp_accept_q, dec_rsp_accept_d;
    logic                    e1_valid_q, e1_valid_d;
    logic [IdWidth-1:0]      e1_id_q, e1_id_d;
    op_e                     e1_op_q, e1_op_d;
    logic [AW-1:0]           e1_prod_q, e1_prod_d;
    logic                    out_valid_q, out_valid_d;
    logic [IdWidth-1:0]      out_id_q, out_id_d;
    logic [RegDataWidth-1:0] out_data_q, out_data_d;
    logic                    out_write_q, out_write_d;
    logic [AW-1:0]           acc_q, acc_d;
    logic                    dec_legal, exe_legal, dec_push, exe_push, e1_adv, e1_xfer;
    logic [AW-1:0]           mac_sum;
    logic                    unused_ok;

    // Legal encodings: custom-0 opcode, zero funct7, funct3 in 000..011.
    assign dec_legal = dec_req_instr[6:0] == 7'b0001011 && dec_req_instr[31:25] == 7'd0 && !dec_req_instr[14];
    assign exe_legal = exe_req_instr[6:0] == 7'b0001011 && exe_req_instr[31:25] == 7'd0 && !exe_req_instr[14];
    assign unused_ok = ^{exe_req_rs_addr, dec_req_instr[24:15], dec_req_instr[13:7],
                         exe_req_instr[24:15], exe_req_instr[11:7]};

    always_comb begin
        dec_req_ready    = !dec_rsp_valid_q || dec_rsp_ready;
        dec_push         = dec_req_valid && dec_req_ready;
        dec_rsp_valid_d  = dec_push || (dec_rsp_valid_q && !dec_rsp_ready);
        dec_rsp_id_d     = dec_push ? dec_req_id : dec_rsp_id_q;
        dec_rsp_accept_d = dec_push ? dec_legal : dec_rsp_accept_q;
        e1_adv           = !out_valid_q || exe_rsp_ready;
        exe_req_ready    = !e1_valid_q || e1_adv;
        exe_push         = exe_req_valid && exe_req_ready && exe_legal;
        e1_valid_d       = exe_push || (e1_valid_q && !e1_adv);
        e1_id_d          = exe_push ? exe_req_id : e1_id_q;
        e1_op_d          = exe_push ? op_e'(exe_req_instr[13:12]) : e1_op_q;
        e1_prod_d        = exe_push ? AW'(exe_req_rs_data[0]) * AW'(exe_req_rs_data[1]) : e1_prod_q;
        e1_xfer          = e1_valid_q && e1_adv;
        out_valid_d      = e1_xfer || (out_valid_q && !exe_rsp_ready);
        out_id_d         = e1_xfer ? e1_id_q : out_id_q;
        mac_sum          = acc_q + e1_prod_q;
        // The accumulator only moves on E1->OUT, so ops retire in program order.
        acc_d            = !e1_xfer ? acc_q :
                           e1_op_q == OP_MAC ? mac_sum :
                           e1_op_q == OP_CLR ? '0 : acc_q;
        out_data_d       = !e1_xfer ? out_data_q :
                           e1_op_q == OP_MAC ? mac_sum[RegDataWidth-1:0] :
                           e1_op_q == OP_RDL ? acc_q[RegDataWidth-1:0] :
                           e1_op_q == OP_RDH ? acc_q[AW-1:RegDataWidth] : '0;
        out_write_d      = e1_xfer ? e1_op_q != OP_CLR : out_write_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dec_rsp_valid_q  <= 1'b0;
            dec_rsp_id_q     <= '0;
            dec_rsp_accept_q <= 1'b0;
            e1_valid_q       <= 1'b0;
            e1_id_q          <= '0;
            e1_op_q          <= OP_MAC;
            e1_prod_q        <= '0;
            out_valid_q      <= 1'b0;
            out_id_q         <= '0;
            out_data_q       <= '0;
            out_write_q      <= 1'b0;
            acc_q            <= '0;
        end else begin
            dec_rsp_valid_q  <= dec_rsp_valid_d;
            dec_rsp_id_q     <= dec_rsp_id_d;
            dec_rsp_accept_q <= dec_rsp_accept_d;
            e1_valid_q       <= e1_valid_d;
            e1_id_q          <= e1_id_d;
            e1_op_q          <= e1_op_d;
            e1_prod_q        <= e1_prod_d;
            out_valid_q      <= out_valid_d;
            out_id_q         <= out_id_d;
            out_data_q       <= out_data_d;
            out_write_q      <= out_write_d;
            acc_q            <= acc_d;
        end
    end

    assign dec_rsp_valid    = dec_rsp_valid_q;
    assign dec_rsp_id       = dec_rsp_id_q;
    assign dec_rsp_accept   = dec_rsp_accept_q;
    assign exe_rsp_valid    = out_valid_q;
    assign exe_rsp_id       = out_id_q;
    assign exe_rsp_rd_data  = out_data_q;
    assign exe_rsp_rd_write = out_write_q;
endmodule

// File: tb/tb_xadac_mac_cop.sv
// tb_xadac_mac_cop: directed plus random checks of xadac_mac_cop against an
// in-order accumulator model that predicts every execute response at issue.
module tb_xadac_mac_cop;
    localparam int IW = 3;
    localparam int RW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_i = 1'b1;
    logic               dec_req_valid = 1'b0, dec_req_ready;
    logic [IW-1:0]      dec_req_id = '0;
    logic [31:0]        dec_req_instr = '0;
    logic               dec_rsp_valid, dec_rsp_ready = 1'b1;
    logic [IW-1:0]      dec_rsp_id;
    logic               dec_rsp_accept;
    logic               exe_req_valid = 1'b0, exe_req_ready;
    logic [IW-1:0]      exe_req_id = '0;
    logic [31:0]        exe_req_instr = '0;
    logic [1:0][RW-1:0] exe_req_rs_data = '0;
    logic [1:0][4:0]    exe_req_rs_addr = '0;
    logic               exe_rsp_valid, exe_rsp_ready = 1'b1;
    logic [IW-1:0]      exe_rsp_id;
    logic [RW-1:0]      exe_rsp_rd_data;
    logic               exe_rsp_rd_write;

    xadac_mac_cop #(.IdWidth(IW), .RegDataWidth(RW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .dec_req_valid(dec_req_valid), .dec_req_ready(dec_req_ready),
        .dec_req_id(dec_req_id), .dec_req_instr(dec_req_instr),
        .dec_rsp_valid(dec_rsp_valid), .dec_rsp_ready(dec_rsp_ready),
        .dec_rsp_id(dec_rsp_id), .dec_rsp_accept(dec_rsp_accept),
        .exe_req_valid(exe_req_valid), .exe_req_ready(exe_req_ready),
        .exe_req_id(exe_req_id), .exe_req_instr(exe_req_instr),
        .exe_req_rs_data(exe_req_rs_data), .exe_req_rs_addr(exe_req_rs_addr),
        .exe_rsp_valid(exe_rsp_valid), .exe_rsp_ready(exe_rsp_ready),
        .exe_rsp_id(exe_rsp_id), .exe_rsp_rd_data(exe_rsp_rd_data),
        .exe_rsp_rd_write(exe_rsp_rd_write)
    );

    typedef struct {logic [IW-1:0] id; logic [31:0] instr; logic [RW-1:0] a; logic [RW-1:0] b;} req_t;
    typedef struct {logic [IW-1:0] id; logic [RW-1:0] data; logic wr;} rsp_t;

    req_t        pend[$];
    rsp_t        expq[$];
    logic [63:0] macc = '0;
    int          n_asserts = 0, n_fail = 0, accepted = 0, acc_n;
    logic        rnd_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic legal(input logic [31:0] i);
        return i[6:0] == 7'h0B && i[31:25] == 7'd0 && i[14:12] <= 3'd3;
    endfunction

    function automatic logic [31:0] mk(input int f3);
        return (32'(f3) << 12) | 32'h0000_000B;
    endfunction

    function automatic req_t rq(input int id, input logic [31:0] instr, input logic [RW-1:0] a, input logic [RW-1:0] b);
        req_t r;
        r.id = IW'(id); r.instr = instr; r.a = a; r.b = b;
        return r;
    endfunction

    // Sequential semantics: each legal op sees the accumulator left by all older ops.
    task automatic model_exec(input req_t r);
        rsp_t e;
        if (!legal(r.instr)) return;
        e.id = r.id;
        e.wr = 1'b1;
        case (r.instr[14:12])
            3'd0: begin macc = macc + {32'd0, r.a} * {32'd0, r.b}; e.data = macc[31:0]; end
            3'd1: begin macc = '0; e.data = '0; e.wr = 1'b0; end
            3'd2: e.data = macc[31:0];
            default: e.data = macc[63:32];
        endcase
        expq.push_back(e);
    endtask

    task automatic cyc();
        if (pend.size() > 0) begin
            exe_req_valid = 1'b1;
            exe_req_id = pend[0].id;
            exe_req_instr = pend[0].instr;
            exe_req_rs_data[0] = pend[0].a;
            exe_req_rs_data[1] = pend[0].b;
        end else exe_req_valid = 1'b0;
        if (rnd_rdy) exe_rsp_ready = 1'($urandom_range(0, 1));
        #1;
        accepted = 0;
        if (rst_i) begin
            expq.delete();
            macc = '0;
        end else begin
            if (exe_rsp_valid) begin
                chk("rsp_expected", 64'(expq.size() > 0), 64'd1);
                if (expq.size() > 0) begin
                    chk("rsp_id", 64'(exe_rsp_id), 64'(expq[0].id));
                    chk("rsp_data", 64'(exe_rsp_rd_data), 64'(expq[0].data));
                    chk("rsp_write", 64'(exe_rsp_rd_write), 64'(expq[0].wr));
                    if (exe_rsp_ready) void'(expq.pop_front());
                end
            end
            if (exe_req_valid && exe_req_ready) begin
                model_exec(pend[0]);
                void'(pend.pop_front());
                accepted = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (expq.size() > 0 || pend.size() > 0); k++) cyc();
        chk("drain_empty", 64'(expq.size() + pend.size()), 64'd0);
        chk("drain_idle", 64'(exe_rsp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(); cyc();
        rst_i = 1'b0;
        #1;
        chk("rst_dec_req_ready", 64'(dec_req_ready), 64'd1);
        chk("rst_exe_req_ready", 64'(exe_req_ready), 64'd1);
        chk("rst_dec_rsp_valid", 64'(dec_rsp_valid), 64'd0);
        chk("rst_exe_rsp_valid", 64'(exe_rsp_valid), 64'd0);
        chk("rst_dec_rsp_id", 64'(dec_rsp_id), 64'd0);
        chk("rst_dec_rsp_accept", 64'(dec_rsp_accept), 64'd0);
        chk("rst_exe_rsp_id", 64'(exe_rsp_id), 64'd0);
        chk("rst_rd_data", 64'(exe_rsp_rd_data), 64'd0);
        chk("rst_rd_write", 64'(exe_rsp_rd_write), 64'd0);

        // Back-to-back MACs with exact latency, then RDH
        pend.push_back(rq(1, mk(0), 32'd3, 32'd5));
        pend.push_back(rq(2, mk(0), 32'hFFFF_FFFF, 32'd2));
        cyc();
        chk("lat_e1_only", 64'(exe_rsp_valid), 64'd0);
        cyc();
        chk("lat_first_valid", 64'(exe_rsp_valid), 64'd1);
        chk("lat_first_data", 64'(exe_rsp_rd_data), 64'h0000_000F);
        cyc();
        chk("lat_second_valid", 64'(exe_rsp_valid), 64'd1);
        chk("lat_second_data", 64'(exe_rsp_rd_data), 64'h0000_000D);
        pend.push_back(rq(3, mk(3), 32'd0, 32'd0));
        drain();
        chk("acc_after_macs", macc, 64'h2_0000_000D);

        // Decode accept / reject and illegal execute
        dec_rsp_ready = 1'b1;
        dec_req_valid = 1'b1; dec_req_id = 3'd5; dec_req_instr = 32'h0000_000B;
        #1 chk("dec_ready_idle", 64'(dec_req_ready), 64'd1);
        cyc();
        dec_req_id = 3'd6; dec_req_instr = 32'h0000_700B;
        chk("dec_valid_1", 64'(dec_rsp_valid), 64'd1);
        chk("dec_id_1", 64'(dec_rsp_id), 64'd5);
        chk("dec_accept_1", 64'(dec_rsp_accept), 64'd1);
        cyc();
        dec_req_valid = 1'b0;
        chk("dec_valid_2", 64'(dec_rsp_valid), 64'd1);
        chk("dec_id_2", 64'(dec_rsp_id), 64'd6);
        chk("dec_accept_2", 64'(dec_rsp_accept), 64'd0);
        cyc();
        chk("dec_drained", 64'(dec_rsp_valid), 64'd0);
        pend.push_back(rq(6, 32'h0000_700B, 32'd7, 32'd9));
        cyc();
        chk("illegal_consumed", 64'(accepted), 64'd1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("illegal_no_rsp", 64'(exe_rsp_valid), 64'd0);
        end
        pend.push_back(rq(1, mk(2), 32'd0, 32'd0));
        pend.push_back(rq(2, mk(3), 32'd0, 32'd0));
        drain();

        // Back-pressure: only E1 and OUT can fill
        exe_rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) pend.push_back(rq(k, mk(0), $urandom, $urandom));
        acc_n = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            acc_n += accepted;
        end
        chk("stall_accepted", 64'(acc_n), 64'd2);
        chk("stall_req_ready", 64'(exe_req_ready), 64'd0);
        exe_rsp_ready = 1'b1;
        drain();

        // CLR after acc=0x1234, then RDL
        pend.push_back(rq(4, mk(1), 32'd0, 32'd0));
        pend.push_back(rq(5, mk(0), 32'h1234, 32'd1));
        pend.push_back(rq(6, mk(1), 32'd0, 32'd0));
        pend.push_back(rq(7, mk(2), 32'd0, 32'd0));
        drain();
        chk("acc_cleared", macc, 64'd0);

        // Random decode traffic
        for (int k = 0; k < 8; k++) begin
            dec_req_valid = 1'b1;
            dec_req_id = IW'($urandom);
            dec_req_instr = ($urandom_range(0, 1) == 1) ? mk($urandom_range(0, 7)) : $urandom;
            cyc();
            chk("rnd_dec_id", 64'(dec_rsp_id), 64'(dec_req_id));
            chk("rnd_dec_accept", 64'(dec_rsp_accept), 64'(legal(dec_req_instr)));
        end
        dec_req_valid = 1'b0;

        // Random execute traffic with random response back-pressure
        for (int k = 0; k < 60; k++) begin
            logic [31:0] ins;
            ins = mk($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) ins[31:25] = 7'($urandom_range(1, 127));
            if ($urandom_range(0, 7) == 0) ins[14:12] = 3'($urandom_range(4, 7));
            pend.push_back(rq($urandom_range(0, 7), ins, $urandom, $urandom));
        end
        rnd_rdy = 1'b1;
        for (int k = 0; k < 600 && pend.size() > 0; k++) cyc();
        rnd_rdy = 1'b0;
        exe_rsp_ready = 1'b1;
        drain();

        // Reset with E1 and OUT both occupied
        exe_rsp_ready = 1'b0;
        pend.push_back(rq(1, mk(0), 32'd11, 32'd13));
        pend.push_back(rq(2, mk(0), 32'd17, 32'd19));
        cyc(); cyc();
        chk("pre_rst_out_valid", 64'(exe_rsp_valid), 64'd1);
        chk("pre_rst_e1_full", 64'(exe_req_ready), 64'd0);
        rst_i = 1'b1;
        pend.delete();
        cyc();
        rst_i = 1'b0;
        exe_rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("post_rst_no_rsp", 64'(exe_rsp_valid), 64'd0);
        end
        pend.push_back(rq(3, mk(2), 32'd0, 32'd0));
        cyc(); cyc();
        chk("post_rst_rdl_valid", 64'(exe_rsp_valid), 64'd1);
        chk("post_rst_rdl_data", 64'(exe_rsp_rd_data), 64'd0);
        drain();

        // Decode slot back-pressure and simultaneous pop/push
        dec_rsp_ready = 1'b0;
        dec_req_valid = 1'b1; dec_req_id = 3'd1; dec_req_instr = mk(2);
        #1 chk("dec_bp_ready_empty", 64'(dec_req_ready), 64'd1);
        cyc();
        dec_req_id = 3'd2; dec_req_instr = mk(3);
        #1 chk("dec_bp_ready_full", 64'(dec_req_ready), 64'd0);
        cyc();
        chk("dec_bp_hold_valid", 64'(dec_rsp_valid), 64'd1);
        chk("dec_bp_hold_id", 64'(dec_rsp_id), 64'd1);
        dec_rsp_ready = 1'b1;
        #1 chk("dec_popush_ready", 64'(dec_req_ready), 64'd1);
        cyc();
        dec_req_valid = 1'b0;
        chk("dec_popush_valid", 64'(dec_rsp_valid), 64'd1);
        chk("dec_popush_id", 64'(dec_rsp_id), 64'd2);
        chk("dec_popush_accept", 64'(dec_rsp_accept), 64'd1);
        cyc();
        chk("dec_final_empty", 64'(dec_rsp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
